// File: rtl/nco_pkg.sv
// Shared NCO definitions: default phase width and sweep FSM state encoding.
// SWEEP_TRIANGLE_EN adds the DOWN state used by the triangle sweep.
package nco_pkg;

  localparam int unsigned NCO_PHASE_WIDTH = 16;

`ifdef SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } sweep_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1
  } sweep_state_t;
`endif

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell timer: loads max(dwell,1)-1, counts down while enabled and pulses
// o_expire for one cycle on the last clock of each dwell, then reloads.
module nco_dwell_timer #(
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_load,
  input  logic                   i_en,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  output logic                   o_expire
);

  logic [DWELL_WIDTH-1:0] r_count;
  logic [DWELL_WIDTH-1:0] r_reload;
  logic [DWELL_WIDTH-1:0] w_dwell_m1;

  // A dwell of 0 is treated as 1, so both reload to a count of 0.
  assign w_dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - DWELL_WIDTH'(1);
  assign o_expire   = i_en && (r_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_count  <= w_dwell_m1;
      r_reload <= w_dwell_m1;
    end else if (i_en) begin
      r_count  <= (r_count == '0) ? r_reload : r_count - DWELL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep driving the NCO phase increment.
// Define SWEEP_TRIANGLE_EN for an up/down triangle sweep instead of up-only.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = NCO_PHASE_WIDTH,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] start_inc,
  input  logic [PHASE_WIDTH-1:0] stop_inc,
  input  logic [PHASE_WIDTH-1:0] step_inc,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [PHASE_WIDTH-1:0] phi_inc_o,
  output logic                   inc_valid,
  output logic                   busy,
  output logic                   done
);

  sweep_state_t           r_state, w_state_nx;
  logic [PHASE_WIDTH-1:0] r_phi, w_phi_nx;
  logic                   r_last, w_last_nx;
  logic                   r_done, w_done_nx;
  logic                   r_pending;
  logic                   w_accept, w_finish, w_expire, w_timer_en;
  logic [PHASE_WIDTH-1:0] r_start, r_stop, r_step;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic                   r_degen;
  logic [PHASE_WIDTH:0]   w_sum;
  logic [PHASE_WIDTH-1:0] w_up_val;
  logic                   w_up_clamp;

  // The wide compare also covers the carry case, since stop_inc < 2**PHASE_WIDTH.
  assign w_sum      = {1'b0, r_phi} + {1'b0, r_step};
  assign w_up_clamp = (w_sum >= {1'b0, r_stop});
  assign w_up_val   = w_up_clamp ? r_stop : w_sum[PHASE_WIDTH-1:0];

`ifdef SWEEP_TRIANGLE_EN
  logic [PHASE_WIDTH:0]   w_diff;
  logic [PHASE_WIDTH-1:0] w_down_val;
  logic                   w_down_clamp;

  assign w_diff       = {1'b0, r_phi} - {1'b0, r_step};
  assign w_down_clamp = w_diff[PHASE_WIDTH] || (w_diff[PHASE_WIDTH-1:0] <= r_start);
  assign w_down_val   = w_down_clamp ? r_start : w_diff[PHASE_WIDTH-1:0];
`endif

  assign w_timer_en = (r_state != ST_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_phi_nx   = r_phi;
    w_last_nx  = r_last;
    w_done_nx  = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (abort) begin
          w_phi_nx = '0;
        end else if (r_pending) begin
          w_state_nx = ST_UP;
          w_phi_nx   = r_start;
          w_last_nx  = r_degen;
        end
      end
      ST_UP: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
          w_phi_nx   = '0;
        end else if (w_expire) begin
          if (r_last) begin
`ifdef SWEEP_TRIANGLE_EN
            if (r_degen) begin
              w_finish = 1'b1;
            end else begin
              w_state_nx = ST_DOWN;
              w_phi_nx   = w_down_val;
              w_last_nx  = w_down_clamp;
            end
`else
            w_finish = 1'b1;
`endif
          end else begin
            w_phi_nx  = w_up_val;
            w_last_nx = w_up_clamp;
          end
        end
      end
`ifdef SWEEP_TRIANGLE_EN
      ST_DOWN: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
          w_phi_nx   = '0;
        end else if (w_expire) begin
          if (r_last) begin
            w_finish = 1'b1;
          end else begin
            w_phi_nx  = w_down_val;
            w_last_nx = w_down_clamp;
          end
        end
      end
`endif
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    if (w_finish) begin
      w_state_nx = ST_IDLE;
      w_done_nx  = 1'b1;
    end
  end

  // A start sampled on the completing edge is accepted as if already idle.
  assign w_accept = start && !abort &&
                    (((r_state == ST_IDLE) && !r_pending) || w_finish);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_phi     <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_pending <= 1'b0;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_degen   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phi     <= w_phi_nx;
      r_last    <= w_last_nx;
      r_done    <= w_done_nx;
      r_pending <= w_accept;
      if (w_accept) begin
        r_start <= start_inc;
        r_stop  <= stop_inc;
        r_step  <= step_inc;
        r_dwell <= dwell_cycles;
        r_degen <= (start_inc >= stop_inc) || (step_inc == '0);
      end
    end
  end

  nco_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (r_pending),
    .i_en    (w_timer_en),
    .i_dwell (r_dwell),
    .o_expire(w_expire)
  );

  assign phi_inc_o = r_phi;
  assign inc_valid = (r_state != ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl; expected increments come from an
// integer reference model of the sweep (triangle when SWEEP_TRIANGLE_EN is set).
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] start_inc = '0;
  logic [15:0] stop_inc = '0;
  logic [15:0] step_inc = '0;
  logic [15:0] dwell_cycles = '0;
  logic [15:0] phi_inc_o;
  logic        inc_valid, busy, done;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_val = '0;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(
    .PHASE_WIDTH(16),
    .DWELL_WIDTH(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .start_inc   (start_inc),
    .stop_inc    (stop_inc),
    .step_inc    (step_inc),
    .dwell_cycles(dwell_cycles),
    .phi_inc_o   (phi_inc_o),
    .inc_valid   (inc_valid),
    .busy        (busy),
    .done        (done)
  );

  task automatic push_expected(input int s, input int e, input int st, input int d);
    int v;
    int dd;
    int vals[$];
    dd = (d == 0) ? 1 : d;
    if (s >= e || st == 0) begin
      vals.push_back(s);
    end else begin
      v = s;
      while (1) begin
        vals.push_back(v);
        if (v + st >= e) begin
          vals.push_back(e);
          break;
        end
        v += st;
      end
`ifdef SWEEP_TRIANGLE_EN
      v = e;
      while (1) begin
        v -= st;
        if (v <= s) begin
          vals.push_back(s);
          break;
        end
        vals.push_back(v);
      end
`endif
    end
    foreach (vals[i]) repeat (dd) exp_q.push_back(16'(vals[i]));
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] e,
                        input logic [15:0] st, input logic [15:0] d);
    @(negedge clk);
    start_inc = s; stop_inc = e; step_inc = st; dwell_cycles = d;
    start = 1'b1;
    push_expected(int'(s), int'(e), int'(st), int'(d));
    @(negedge clk);
    start = 1'b0;
    start_inc = 16'($urandom);
    stop_inc  = 16'($urandom);
    step_inc  = 16'($urandom);
    dwell_cycles = 16'($urandom_range(0, 5));
  endtask

  task automatic sb_pop(input string name);
    logic [15:0] e;
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front();
    last_val = e;
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== {e, 3'b110}) begin
      n_fail++;
      $display("FAIL %s: phi=%h valid=%b busy=%b done=%b, required phi=%h valid=1 busy=1 done=0",
               name, phi_inc_o, inc_valid, busy, done, e);
    end
  endtask

  task automatic drain(input string name);
    while (exp_q.size() != 0) sb_pop(name);
  endtask

  task automatic check_done(input string name);
    @(negedge clk);
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== {last_val, 3'b001}) begin
      n_fail++;
      $display("FAIL %s_done: phi=%h valid=%b busy=%b done=%b, required phi=%h valid=0 busy=0 done=1",
               name, phi_inc_o, inc_valid, busy, done, last_val);
    end
    @(negedge clk);
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== {last_val, 3'b000}) begin
      n_fail++;
      $display("FAIL %s_hold: phi=%h valid=%b busy=%b done=%b, required phi=%h valid=0 busy=0 done=0",
               name, phi_inc_o, inc_valid, busy, done, last_val);
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset: phi=%h valid=%b busy=%b done=%b, required all 0",
                 phi_inc_o, inc_valid, busy, done);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_up();
    launch(16'd100, 16'd400, 16'd100, 16'd3);
    drain("basic_up");
    check_done("basic_up");
  endtask

  task automatic test_clamp_carry();
    launch(16'hFF00, 16'hFFF0, 16'h0080, 16'd1);
    drain("clamp_carry");
    check_done("clamp_carry");
  endtask

  task automatic test_degenerate();
    launch(16'd500, 16'd200, 16'd100, 16'd2);
    drain("degen_order");
    check_done("degen_order");
    launch(16'd10, 16'd20, 16'd0, 16'd2);
    drain("degen_step0");
    check_done("degen_step0");
  endtask

  task automatic test_dwell_zero();
    launch(16'd100, 16'd300, 16'd100, 16'd0);
    drain("dwell_zero");
    check_done("dwell_zero");
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
      n_fail++;
      $display("FAIL abort_idle: phi=%h valid=%b busy=%b done=%b, required all 0",
               phi_inc_o, inc_valid, busy, done);
    end
  endtask

  task automatic test_abort_mid();
    launch(16'd100, 16'd400, 16'd100, 16'd3);
    repeat (4) sb_pop("abort_mid_pre");
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
        n_fail++;
        $display("FAIL abort_mid: phi=%h valid=%b busy=%b done=%b, required all 0",
                 phi_inc_o, inc_valid, busy, done);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_start_while_busy();
    launch(16'd1000, 16'd1300, 16'd100, 16'd2);
    repeat (2) sb_pop("busy_start");
    start_inc = 16'd5; stop_inc = 16'd9000; step_inc = 16'd1; dwell_cycles = 16'd1;
    start = 1'b1;
    drain("busy_start");
    check_done("busy_start");
  endtask

  task automatic test_start_abort_same();
    @(negedge clk);
    start_inc = 16'd55; stop_inc = 16'd99; step_inc = 16'd4; dwell_cycles = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_tests++;
      if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
        n_fail++;
        $display("FAIL start_abort: phi=%h valid=%b busy=%b done=%b, required all 0",
                 phi_inc_o, inc_valid, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(16'd100, 16'd300, 16'd100, 16'd1);
    drain("b2b_first");
    start_inc = 16'd7; stop_inc = 16'd9; step_inc = 16'd1; dwell_cycles = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== {last_val, 3'b001}) begin
      n_fail++;
      $display("FAIL b2b_done: phi=%h valid=%b busy=%b done=%b, required phi=%h valid=0 busy=0 done=1",
               phi_inc_o, inc_valid, busy, done, last_val);
    end
    push_expected(7, 9, 1, 1);
    drain("b2b_second");
    check_done("b2b_second");
  endtask

  task automatic test_reset_mid();
    launch(16'd100, 16'd400, 16'd100, 16'd2);
    repeat (3) sb_pop("reset_mid_pre");
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: phi=%h valid=%b busy=%b done=%b, required all 0",
               phi_inc_o, inc_valid, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({phi_inc_o, inc_valid, busy, done} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_mid_after: phi=%h valid=%b busy=%b done=%b, required all 0",
                 phi_inc_o, inc_valid, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_clamp_carry();
    test_degenerate();
    test_dwell_zero();
    test_abort_idle();
    test_abort_mid();
    test_start_while_busy();
    test_start_abort_same();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
